// File: rtl/edp_pkg.sv
// edp_pkg: shared EDP codes (AD functions, ADB/MQ selects) and the multiply FSM states
package edp_pkg;
  localparam logic [5:0] AD_A    = 6'o37;
  localparam logic [5:0] AD_APB  = 6'o06;
  localparam logic [5:0] AD_AMB  = 6'o51;
  localparam logic [5:0] AD_ZERO = 6'o34;
  localparam logic [1:0] ADB_NONE = 2'b00;
  localparam logic [1:0] ADB_BR   = 2'b10;
  localparam logic [1:0] MQ_LOAD = 2'b00;
  localparam logic [1:0] MQ_SHL  = 2'b01;
  localparam logic [1:0] MQ_SHR  = 2'b10;
  localparam logic [1:0] MQ_HOLD = 2'b11;
  typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;
endpackage

// File: rtl/edp_mul_seq_if.sv
// edp_mul_seq_if: multiply sequencer bus.
//   master (requester): drives start, abort, mq35; observes status and datapath controls.
//   slave (sequencer): drives busy, done, adFunc, adbSel, adaEn, arLoad, arxLoad, arShr, mqSel, stepCount.
interface edp_mul_seq_if #(parameter int SW = 6);
  logic start, abort, mq35;
  logic busy, done, adaEn, arLoad, arxLoad, arShr;
  logic [5:0] adFunc;
  logic [1:0] adbSel, mqSel;
  logic [SW-1:0] stepCount;
  modport master (
    output start, abort, mq35,
    input  busy, done, adFunc, adbSel, adaEn, arLoad, arxLoad, arShr, mqSel, stepCount
  );
  modport slave (
    input  start, abort, mq35,
    output busy, done, adFunc, adbSel, adaEn, arLoad, arxLoad, arShr, mqSel, stepCount
  );
endinterface

// File: rtl/edp_booth_dec.sv
// edp_booth_dec: radix-2 Booth recode of {mq35, prev} into an AD function code.
//   mq35, prev: current and previous multiplier bits; ad_func: A-B, A+B or A.
module edp_booth_dec
  import edp_pkg::*;
(
  input  logic       mq35,
  input  logic       prev,
  output logic [5:0] ad_func
);
  always_comb ad_func = (mq35 && !prev) ? AD_AMB : (!mq35 && prev) ? AD_APB : AD_A;
endmodule

// File: rtl/edp_mul_seq.sv
// edp_mul_seq: Booth multiply sequencer driving the EDP AD/AR/MQ controls.
//   eboxClk, eboxReset: clock and synchronous active-high reset.
//   bus (slave): start/abort/mq35 in; busy, done, AD/ADB/AR/MQ controls and stepCount out.
module edp_mul_seq
  import edp_pkg::*;
#(
  parameter int STEPS = 36,
  parameter int SW    = 6
) (
  input logic            eboxClk,
  input logic            eboxReset,
  edp_mul_seq_if.slave   bus
);
  state_t state, state_nxt;
  logic prev;
  logic [SW-1:0] step_count;
  logic [5:0] booth_func;
  edp_booth_dec u_dec (
    .mq35    (bus.mq35),
    .prev    (prev),
    .ad_func (booth_func)
  );
  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      state      <= IDLE;
      prev       <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        prev       <= 1'b0;
        step_count <= SW'(STEPS - 1);
      end else if (state == STEP) begin
        prev <= bus.mq35;
        if (step_count != '0) step_count <= step_count - 1'b1;
      end
    end
  end
  // An aborted cycle suppresses its AR/MQ update so the datapath keeps what it had.
  always_comb begin
    state_nxt  = state;
    bus.adFunc = AD_A;
    bus.adbSel = ADB_NONE;
    bus.adaEn  = 1'b0;
    bus.arLoad = 1'b0;
    bus.arShr  = 1'b0;
    bus.mqSel  = MQ_HOLD;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: state_nxt = (bus.start && !bus.abort) ? INIT : IDLE;
      INIT: begin
        bus.adFunc = AD_ZERO;
        bus.arLoad = !bus.abort;
        bus.busy   = 1'b1;
        state_nxt  = bus.abort ? IDLE : STEP;
      end
      STEP: begin
        bus.adFunc = booth_func;
        bus.adaEn  = 1'b1;
        bus.adbSel = ADB_BR;
        bus.arLoad = !bus.abort;
        bus.arShr  = 1'b1;
        bus.mqSel  = bus.abort ? MQ_HOLD : MQ_SHR;
        bus.busy   = 1'b1;
        state_nxt  = bus.abort ? IDLE : (step_count == '0) ? DONE : STEP;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end
  assign bus.arxLoad   = 1'b0;
  assign bus.stepCount = step_count;
endmodule

// File: doc/edp_mul_seq.md
EDP_MUL_SEQ -- requirements
Module: edp_mul_seq

Interface
REQ-001 Parameters: STEPS, default 36, number of multiply steps (one per multiplier bit); SW, default 6, step-counter width, which SHALL satisfy 2**SW >= STEPS.
REQ-002 eboxClk  input  1  EBOX clock; all state changes on the rising edge.
REQ-003 eboxReset  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a multiply; operands are already in MQ (multiplier) and BR (multiplicand).
REQ-005 abort  input  1  cancel an operation in progress.
REQ-006 mq35  input  1  current EDP_MQ[35].
REQ-007 busy  output  1  high from the first INIT cycle through the last STEP cycle.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 adFunc  output  6  AD function code (octal): A=37, A+B=06, A-B=51, 0S=34.
REQ-010 adbSel  output  2  ADB select; 2'b10 = BR.
REQ-011 adaEn  output  1  ADA enable; ADA source is AR.
REQ-012 arLoad, arxLoad  output  1 each  AR and ARX load strobes.
REQ-013 arShr  output  1  1 = AR takes AD shifted right one bit (AD sign replicated); 0 = AR takes AD unshifted.
REQ-014 mqSel  output  2  MQ universal-register function: LOAD=00, SHL=01, SHR=10, HOLD=11.
REQ-015 stepCount  output  SW  number of steps remaining.

Function
REQ-016 The FSM SHALL have four states: IDLE, INIT, STEP, DONE.
REQ-017 IDLE: outputs adFunc=37, adaEn=0, arLoad=0, arxLoad=0, mqSel=HOLD, busy=0, done=0; on start, next state is INIT.
REQ-018 INIT, one cycle: adFunc=34 (0S), arLoad=1, arShr=0, mqSel=HOLD, prev<=0, stepCount<=STEPS-1; next state is STEP.
REQ-019 STEP: the Booth pair {mq35,prev} SHALL select the AD function: 10 -> A-B (51); 01 -> A+B (06); 00 or 11 -> A (37).
REQ-020 STEP controls: adaEn=1, adbSel=2'b10, arLoad=1, arShr=1, mqSel=SHR (AD[35] shifted into MQ[0]), and prev<=mq35.
REQ-021 In STEP, when stepCount=0 the next state is DONE; otherwise stepCount decrements by 1.
REQ-022 DONE, one cycle: done=1, mqSel=HOLD, no loads; next state is IDLE.
REQ-023 Latency: with start sampled at cycle 0, INIT is cycle 1, STEP occupies cycles 2..STEPS+1, and done is high at cycle STEPS+2 (cycle 38 at the default).
REQ-024 start while not in IDLE SHALL be ignored, with no queueing.
REQ-025 abort in INIT or STEP SHALL force IDLE on the next edge; no done pulse; AR and MQ contents are left as-is.
REQ-026 abort and start asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-027 abort in DONE SHALL be ignored; the done pulse completes.
REQ-028 arxLoad SHALL be 0 in every state; it is reserved for the double-word extension.

Reset
REQ-029 eboxReset SHALL force IDLE, prev=0 and stepCount=0; all outputs then take their IDLE values on the next cycle.
REQ-030 eboxReset SHALL take priority over start and abort, including mid-operation, and no done pulse is produced.

Structure
REQ-031 A shared package edp_pkg SHALL hold the AD function codes (37, 06, 51, 34), the MQ select codes (LOAD/SHL/SHR/HOLD), the ADB select codes and the state enumeration.
REQ-032 One sub-module, edp_booth_dec, SHALL map {mq35,prev} to adFunc; it is purely combinational.
REQ-033 The design SHALL have no combinational path from start to any output.

Verification
REQ-034 Multiplier=5, multiplicand=3 -> adFunc sequence 51,06,51,06,37 followed by 37 for the remaining 31 steps; done at cycle 38; product 15 in AR/MQ.
REQ-035 Multiplier=-1 (all ones), multiplicand=7 -> first step 51, remaining 35 steps 37; product -7.
REQ-036 Start at cycle 0, abort at cycle 10 -> busy low at cycle 11, no done pulse; a new start at cycle 12 runs to completion with done at cycle 50.
REQ-037 Start pulsed again at cycle 5 during an operation -> ignored; exactly one done, at cycle 38.
REQ-038 eboxReset at cycle 20 mid-STEP -> IDLE at cycle 21, stepCount=0, no done pulse.
REQ-039 start and abort together in IDLE -> remains IDLE; busy never asserts.
